psum_drain: RTL and testbench
=============================

# psum_drain

Read-side responder for the PE-row partial-sum scratchpad. Sits at the right edge of a systolic PE row and drains the final accumulated results from the last PE's scratchpad using the `read_req`/`Read_ready` handshake. Results are buffered in a small FIFO and streamed to the output collector over valid/ready. After a frame is drained, the block issues a one-cycle `inner_reset` so the scratchpad can start the next frame.

## Interface
- `MATRIX_SIZE`, 3, matrix dimension; sets result width.
- `OUTPUT_WIDTH`, `$clog2(MATRIX_SIZE*256)-1`, signed partial-sum width; default is 9.
- `FRAME_LEN`, 9, results read per frame (one full scratchpad pointer cycle).
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset. Asynchronous, active-low.
- `start` in 1: arms a frame drain; sampled only in IDLE.
- `sp_read_ready` in 1: scratchpad has valid accumulated data.
- `sp_read_req` out 1: read request to the scratchpad.
- `sp_r_data` in OUTPUT_WIDTH: scratchpad read data, signed, registered by the scratchpad.
- `sp_inner_reset` out 1: one-cycle synchronous clear pulse to the scratchpad.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out OUTPUT_WIDTH: result, signed.
- `out_last` out 1: marks the final word of the frame.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse, coincident with `sp_inner_reset`.

## Operation
- FSM has four states: IDLE, DRAIN, FLUSH, CLEAR.
- IDLE:
  - `start`=1 → DRAIN.
  - Entering DRAIN clears `issued_cnt`, `captured_cnt` and `pending`.
  - The FIFO is already empty at this point.
- DRAIN:
  - `sp_read_req` = (`issued_cnt` < FRAME_LEN) && (`fifo_count` + `pending` < FIFO_DEPTH). It is combinational from registered state.
  - A read is accepted when `sp_read_req` && `sp_read_ready`. On acceptance: `issued_cnt`++ and `pending`←1; otherwise `pending`←0.
  - If `pending`=1, `sp_r_data` is pushed into the FIFO this cycle and `captured_cnt`++.
  - When `issued_cnt` reaches FRAME_LEN → FLUSH.
- FLUSH:
  - Any remaining pending capture completes.
  - Wait for `captured_cnt`=FRAME_LEN and FIFO empty (last pop done) → CLEAR.
- CLEAR:
  - `sp_inner_reset`=1 and `frame_done`=1 for exactly one cycle → IDLE.
- FIFO:
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pop occurs on `out_valid` && `out_ready`.
  - `out_valid` = FIFO non-empty. `out_data` is the head entry.
- `out_last` is high when the head entry is capture index FRAME_LEN-1. Each entry carries a stored last bit.
- `start` while busy is ignored.
- `sp_read_ready` deasserting mid-frame only stalls reads; no error is raised.
- The FIFO never overflows. The request throttle reserves a slot for the in-flight read.

## Timing
- Reset values: `sp_read_req`=0, `sp_inner_reset`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `frame_done`=0. FSM is in IDLE, FIFO is empty, all counters are 0.
- Read latency: data for a read accepted at edge N is sampled from `sp_r_data` at edge N+1.
- FIFO latency: pushed at edge N+1, the word is visible on `out_data`/`out_valid` after edge N+1.
- Minimum start-to-first-`out_valid`: 2 cycles after DRAIN entry, with `sp_read_ready` held high.
- Throughput is 1 word/cycle when `out_ready`=1 and `sp_read_ready`=1.
- Drained frame end: CLEAR follows the cycle in which the FIFO becomes empty. IDLE follows one cycle later.
- `reset_n` asserted mid-frame: immediate return to reset values and FIFO contents discarded. No `sp_inner_reset` pulse is generated.

## Configuration
- `PSUM_RELU_EN` defined: every word pushed into the FIFO is clamped to 0 if negative (ReLU at the array edge).
- `PSUM_RELU_EN` undefined: raw signed values pass unchanged.
- Timing is identical in both cases.

## Test plan
- Basic frame: `start`, `sp_read_ready`=1, `out_ready`=1, scratchpad returns 1..9. Expect `out_data` 1..9 on consecutive cycles and `out_last` on 9. Then `sp_inner_reset`/`frame_done` pulse once and `busy` falls the next cycle.
- Backpressure: `out_ready`=0 for 10 cycles mid-frame. Expect `sp_read_req` to drop once `fifo_count`+`pending`=4, with no lost or duplicated words. Order 1..9 is preserved after release.
- Ready stall: `sp_read_ready` toggles 1,0,0,1 repeatedly. Expect `issued_cnt` to advance only on accepted cycles, exactly 9 captures, and a correct `out_last`.
- Signed/ReLU: scratchpad returns -5, 255, -256. Without `PSUM_RELU_EN` expect -5, 255, -256. With it expect 0, 255, 0.
- Reset mid-frame: assert `reset_n`=0 after 4 words. Expect all outputs at reset values with no `sp_inner_reset`. A new `start` then drains a full 9-word frame correctly.
- Busy start: pulse `start` in DRAIN and FLUSH. Expect no restart, counters unaffected, and exactly one `frame_done`.

Source files
------------

// File: rtl/psum_drain.sv
// Partial-sum drain: reads a frame from the PE-row scratchpad, buffers it in a small FIFO and
// streams it out over valid/ready. Define PSUM_RELU_EN to clamp negative results to zero.
module psum_drain #(
   parameter int MATRIX_SIZE  = 3,
   parameter int OUTPUT_WIDTH = $clog2(MATRIX_SIZE*256)-1,
   parameter int FRAME_LEN    = 9,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    sp_read_ready,
   output logic                    sp_read_req,
   input  logic [OUTPUT_WIDTH-1:0] sp_r_data,
   output logic                    sp_inner_reset,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUTPUT_WIDTH-1:0] out_data,
   output logic                    out_last,
   output logic                    busy,
   output logic                    frame_done
);

   localparam int CNTW = $clog2(FRAME_LEN+1);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CW   = $clog2(FIFO_DEPTH+1);
   localparam logic [CNTW-1:0] FRAME_END  = CNTW'(FRAME_LEN);
   localparam logic [CNTW-1:0] FRAME_LAST = CNTW'(FRAME_LEN-1);
   localparam logic [CW-1:0]   DEPTH_C    = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, CLEAR} state_t;
   state_t state, state_nxt;

   logic [CNTW-1:0]         issued_cnt, captured_cnt;
   logic                    pending;
   logic [OUTPUT_WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic                    mem_last [FIFO_DEPTH];
   logic [PW-1:0]           wr_ptr, rd_ptr;
   logic [CW-1:0]           fifo_count;
   logic                    accept, push, pop, fifo_empty, start_frame;
   logic [OUTPUT_WIDTH-1:0] push_data;

`ifdef PSUM_RELU_EN
   assign push_data = sp_r_data[OUTPUT_WIDTH-1] ? '0 : sp_r_data;
`else
   assign push_data = sp_r_data;
`endif

   assign start_frame = (state == IDLE) && start;
   assign accept      = sp_read_req && sp_read_ready;
   assign push        = pending;
   assign fifo_empty  = (fifo_count == '0);
   assign out_valid   = !fifo_empty;
   assign pop         = out_valid && out_ready;
   assign out_data    = out_valid ? mem_data[rd_ptr] : '0;
   assign out_last    = out_valid ? mem_last[rd_ptr] : 1'b0;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // The request throttle counts the in-flight read so a returning word always has a free slot.
   always_comb begin
      state_nxt      = state;
      sp_read_req    = 1'b0;
      sp_inner_reset = 1'b0;
      frame_done     = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = DRAIN;
         DRAIN: begin
            sp_read_req = (issued_cnt < FRAME_END) && ((fifo_count + CW'(pending)) < DEPTH_C);
            if (sp_read_req && sp_read_ready && (issued_cnt == FRAME_LAST)) state_nxt = FLUSH;
         end
         FLUSH: if ((captured_cnt == FRAME_END) && fifo_empty && !pending) state_nxt = CLEAR;
         CLEAR: begin
            sp_inner_reset = 1'b1;
            frame_done     = 1'b1;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         issued_cnt   <= '0;
         captured_cnt <= '0;
         pending      <= 1'b0;
      end else if (start_frame) begin
         issued_cnt   <= '0;
         captured_cnt <= '0;
         pending      <= 1'b0;
      end else begin
         pending <= accept;
         if (accept)  issued_cnt   <= issued_cnt + 1'b1;
         if (pending) captured_cnt <= captured_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= push_data;
         mem_last[wr_ptr] <= (captured_cnt == FRAME_LAST);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: a cycle table for the basic frame plus scoreboarded
// frames under backpressure, read stalls, signed data, mid-frame reset and busy starts.
module tb_psum_drain;
   localparam int OW         = 9;
   localparam int FRAME_LEN  = 9;
   localparam int FIFO_DEPTH = 4;

   logic clk = 1'b0;
   logic reset_n, start, sp_read_ready, sp_read_req, sp_inner_reset;
   logic out_valid, out_ready, out_last, busy, frame_done;
   logic [OW-1:0] sp_r_data, out_data;

   always #5 clk = ~clk;

   psum_drain #(.MATRIX_SIZE(3), .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .sp_read_ready(sp_read_ready),
      .sp_read_req(sp_read_req), .sp_r_data(sp_r_data), .sp_inner_reset(sp_inner_reset),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .frame_done(frame_done)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic signed [OW-1:0] sp_words [FRAME_LEN];
   int acc_cnt, pop_cnt, done_cnt;
   bit t_acc, t_pop;
   logic signed [OW-1:0] t_data;
   logic t_last;

   typedef struct {
      bit start; bit sp_rdy; bit o_rdy;
      bit e_valid; int e_data; bit e_last; bit e_busy; bit e_done; bit e_req;
   } vec_t;
   vec_t tbl [15];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int model_word(input int v);
`ifdef PSUM_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   // One clock: sample handshakes before the edge, then act as a registered scratchpad.
   task automatic tick();
      #1;
      t_acc  = sp_read_req && sp_read_ready;
      t_pop  = out_valid && out_ready;
      t_data = out_data;
      t_last = out_last;
      @(posedge clk);
      #1;
      if (t_acc) begin
         if (acc_cnt < FRAME_LEN) sp_r_data = sp_words[acc_cnt];
         acc_cnt++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"}, sp_read_req, 0);
      check({tag, "_inner_reset"}, sp_inner_reset, 0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_data"}, out_data, 0);
      check({tag, "_last"}, out_last, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, frame_done, 0);
   endtask

   function automatic vec_t mk(bit st, bit v, int d, bit l, bit b, bit dn, bit rq);
      vec_t r;
      r.start = st; r.sp_rdy = 1'b1; r.o_rdy = 1'b1;
      r.e_valid = v; r.e_data = d; r.e_last = l; r.e_busy = b; r.e_done = dn; r.e_req = rq;
      return r;
   endfunction

   // mode 0: all ready; 1: sp_read_ready 1,0,0,1; 2: random; 3: out_ready low for 10 cycles
   task automatic run_frame(input string tag, input int mode, input bit busy_start, input int abort_at);
      int exp_q[$];
      bit seen_done, finished;
      for (int i = 0; i < FRAME_LEN; i++) exp_q.push_back(model_word(int'(sp_words[i])));
      acc_cnt = 0; pop_cnt = 0; done_cnt = 0; seen_done = 0; finished = 0;
      start = 1'b1; sp_read_ready = 1'b1; out_ready = 1'b1;
      tick();
      if (!busy_start) start = 1'b0;
      for (int c = 1; c <= 400 && !finished; c++) begin
         case (mode)
            1: begin sp_read_ready = (c % 4 == 1) || (c % 4 == 0); out_ready = 1'b1; end
            2: begin sp_read_ready = 1'($urandom_range(0, 1)); out_ready = ($urandom_range(0, 3) != 0); end
            3: begin sp_read_ready = 1'b1; out_ready = (c > 10); end
            default: begin sp_read_ready = 1'b1; out_ready = 1'b1; end
         endcase
         if (seen_done) start = 1'b0;
         tick();
         if (t_pop) begin
            if (pop_cnt < FRAME_LEN) begin
               check({tag, "_data"}, longint'(t_data), exp_q[pop_cnt]);
               check({tag, "_last"}, t_last, (pop_cnt == FRAME_LEN-1));
            end else check({tag, "_extra_word"}, pop_cnt, FRAME_LEN-1);
            pop_cnt++;
         end
         check({tag, "_no_overflow"}, (acc_cnt - pop_cnt) <= FIFO_DEPTH, 1);
         check({tag, "_pulse_pair"}, sp_inner_reset, frame_done);
         if (mode == 3 && c == 10) begin
            check({tag, "_throttle_req"}, sp_read_req, 0);
            check({tag, "_throttle_reads"}, acc_cnt, FIFO_DEPTH);
         end
         if (abort_at > 0 && pop_cnt == abort_at) begin
            #2 reset_n = 1'b0;
            #1 check_reset_outputs({tag, "_in_reset"});
            @(posedge clk); #1;
            check_reset_outputs({tag, "_held_reset"});
            reset_n = 1'b1; start = 1'b0;
            return;
         end
         if (seen_done) begin
            check({tag, "_busy_fall"}, busy, 0);
            finished = 1;
         end else if (frame_done) begin
            seen_done = 1; done_cnt++;
            check({tag, "_busy_at_done"}, busy, 1);
         end
      end
      start = 1'b0;
      check({tag, "_completed"}, finished, 1);
      check({tag, "_pops"}, pop_cnt, FRAME_LEN);
      check({tag, "_reads"}, acc_cnt, FRAME_LEN);
      check({tag, "_done_count"}, done_cnt, 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check({tag, "_idle_done"}, frame_done, 0);
         check({tag, "_idle_busy"}, busy, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; sp_read_ready = 1'b0; out_ready = 1'b0; sp_r_data = '0;
      acc_cnt = 0;
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("reset");
      reset_n = 1'b1;

      // basic frame, cycle by cycle; row k shows outputs after the k-th edge from start
      for (int i = 0; i < FRAME_LEN; i++) sp_words[i] = OW'(i + 1);
      tbl[0]  = mk(1, 0, 0, 0, 1, 0, 1);
      tbl[1]  = mk(0, 0, 0, 0, 1, 0, 1);
      for (int r = 2; r <= 8; r++) tbl[r] = mk(0, 1, r - 1, 0, 1, 0, 1);
      tbl[9]  = mk(0, 1, 8, 0, 1, 0, 0);
      tbl[10] = mk(0, 1, 9, 1, 1, 0, 0);
      tbl[11] = mk(0, 0, 0, 0, 1, 0, 0);
      tbl[12] = mk(0, 0, 0, 0, 1, 1, 0);
      tbl[13] = mk(0, 0, 0, 0, 0, 0, 0);
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 0);
      acc_cnt = 0;
      for (int r = 0; r < 15; r++) begin
         start = tbl[r].start; sp_read_ready = tbl[r].sp_rdy; out_ready = tbl[r].o_rdy;
         tick();
         check($sformatf("tbl%0d_valid", r), out_valid, tbl[r].e_valid);
         if (tbl[r].e_valid) begin
            check($sformatf("tbl%0d_data", r), longint'($signed(out_data)), tbl[r].e_data);
            check($sformatf("tbl%0d_last", r), out_last, tbl[r].e_last);
         end
         check($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
         check($sformatf("tbl%0d_done", r), frame_done, tbl[r].e_done);
         check($sformatf("tbl%0d_inner_reset", r), sp_inner_reset, tbl[r].e_done);
         check($sformatf("tbl%0d_req", r), sp_read_req, tbl[r].e_req);
      end

      run_frame("backpressure", 3, 0, 0);
      run_frame("ready_stall", 1, 0, 0);

      sp_words[0] = -9'sd5; sp_words[1] = 9'sd255; sp_words[2] = -9'sd256;
      for (int i = 3; i < FRAME_LEN; i++) sp_words[i] = OW'(i);
      run_frame("signed", 0, 0, 0);

      for (int i = 0; i < FRAME_LEN; i++) sp_words[i] = OW'(10 + i);
      run_frame("abort", 0, 0, 4);
      tick();
      check_reset_outputs("after_abort");
      run_frame("post_reset", 0, 0, 0);

      run_frame("busy_start", 0, 1, 0);
      run_frame("busy_start_stall", 1, 1, 0);

      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < FRAME_LEN; i++) sp_words[i] = OW'($urandom);
         run_frame($sformatf("random%0d", f), 2, 1'($urandom_range(0, 1)), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
